// File: rtl/midi_rx_parser.sv
// MIDI input: 2-FF synchronized 8N1 UART receiver feeding a channel-message parser.
// Handles running status, real-time interleaving, SysEx skipping and channel filtering.
module midi_rx_parser #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 31_250,
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        midi_rx_in,
    output logic [23:0] midi_event,
    output logic        event_valid,
    output logic        framing_error
);
    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [3:0]       CH        = 4'(CHANNEL);

    typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT_HIGH} ustate_t;
    typedef enum logic [1:0] {P_IDLE, P_D1, P_D2} pstate_t;

    logic             sync1_q, sync2_q;
    ustate_t          ustate_q, ustate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitn_q, bitn_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_vld_q, byte_vld_d;
    logic             ferr_c;

    pstate_t          pstate_q, pstate_d;
    logic [7:0]       rs_q, rs_d;
    logic             rs_vld_q, rs_vld_d;
    logic [7:0]       d1_q, d1_d;
    logic [23:0]      event_q, event_d;
    logic             event_vld_q, event_vld_d;

    function automatic logic is_two_byte(input logic [7:0] st);
        return (st[7:4] == 4'hC) || (st[7:4] == 4'hD);
    endfunction

    // Note-on with zero velocity is reported as note-off on the same channel.
    function automatic logic [7:0] emit_status(input logic [7:0] st, input logic [7:0] d2);
        if (st[7:4] == 4'h9 && d2 == 8'h00)
            return {4'h8, st[3:0]};
        return st;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            ustate_q    <= U_IDLE;
            cnt_q       <= '0;
            bitn_q      <= '0;
            byte_vld_q  <= 1'b0;
            pstate_q    <= P_IDLE;
            rs_q        <= '0;
            rs_vld_q    <= 1'b0;
            event_q     <= '0;
            event_vld_q <= 1'b0;
        end else begin
            sync1_q     <= midi_rx_in;
            sync2_q     <= sync1_q;
            ustate_q    <= ustate_d;
            cnt_q       <= cnt_d;
            bitn_q      <= bitn_d;
            byte_vld_q  <= byte_vld_d;
            pstate_q    <= pstate_d;
            rs_q        <= rs_d;
            rs_vld_q    <= rs_vld_d;
            event_q     <= event_d;
            event_vld_q <= event_vld_d;
        end
    end

    always_ff @(posedge clk_in) begin
        shift_q <= shift_d;
        d1_q    <= d1_d;
    end

    always_comb begin
        ustate_d   = ustate_q;
        cnt_d      = cnt_q + 1'b1;
        bitn_d     = bitn_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        ferr_c     = 1'b0;
        case (ustate_q)
            U_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) ustate_d = U_START;
            end
            U_START: begin
                // Mid-start-bit check rejects short glitches on the idle line.
                if (cnt_q == HALF_LAST) begin
                    cnt_d    = '0;
                    bitn_d   = '0;
                    ustate_d = sync2_q ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) ustate_d = U_STOP;
                end
            end
            U_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        byte_vld_d = 1'b1;
                        ustate_d   = U_IDLE;
                    end else begin
                        ferr_c   = 1'b1;
                        ustate_d = U_WAIT_HIGH;
                    end
                end
            end
            U_WAIT_HIGH: begin
                cnt_d = '0;
                if (sync2_q) ustate_d = U_IDLE;
            end
            default: ustate_d = U_IDLE;
        endcase
    end

    logic        done_c;
    logic [7:0]  c1_c, c2_c;

    always_comb begin
        pstate_d    = pstate_q;
        rs_d        = rs_q;
        rs_vld_d    = rs_vld_q;
        d1_d        = d1_q;
        event_d     = event_q;
        event_vld_d = 1'b0;
        done_c      = 1'b0;
        c1_c        = 8'h00;
        c2_c        = 8'h00;
        if (byte_vld_q) begin
            if (shift_q >= 8'hF8) begin
                pstate_d = pstate_q;
            end else if (shift_q >= 8'hF0) begin
                rs_vld_d = 1'b0;
                pstate_d = P_IDLE;
            end else if (shift_q[7]) begin
                rs_d     = shift_q;
                rs_vld_d = 1'b1;
                pstate_d = is_two_byte(shift_q) ? P_D2 : P_D1;
            end else begin
                case (pstate_q)
                    P_IDLE: begin
                        if (rs_vld_q) begin
                            if (is_two_byte(rs_q)) begin
                                done_c = 1'b1;
                                c1_c   = shift_q;
                            end else begin
                                d1_d     = shift_q;
                                pstate_d = P_D2;
                            end
                        end
                    end
                    P_D1: begin
                        d1_d     = shift_q;
                        pstate_d = P_D2;
                    end
                    P_D2: begin
                        pstate_d = P_IDLE;
                        done_c   = 1'b1;
                        if (is_two_byte(rs_q)) begin
                            c1_c = shift_q;
                        end else begin
                            c1_c = d1_q;
                            c2_c = shift_q;
                        end
                    end
                    default: pstate_d = P_IDLE;
                endcase
            end
        end
        if (done_c && (OMNI != 0 || rs_q[3:0] == CH)) begin
            event_d     = {emit_status(rs_q, c2_c), c1_c, c2_c};
            event_vld_d = 1'b1;
        end
    end

    assign midi_event    = event_q;
    assign event_valid   = event_vld_q;
    assign framing_error = ferr_c;
endmodule

// File: doc/midi_rx_parser.md
# midi_rx_parser

Receives the raw MIDI serial stream from the DIN/opto input and converts it into the 24-bit `midi_event` word consumed by `midi`. The event word is packed as {status, data1, data2}. Internally it is an 8N1 UART receiver feeding a MIDI message parser. The parser handles running status, real-time byte interleaving, SysEx skipping and channel filtering. It sits between the board pin and `midi`, with `midi_event` held stable between events.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 31_250: serial bit rate. Bit period `BIT_CYC = CLK_HZ/BAUD`, integer, and must be ≥ 4.
- `CHANNEL`, 0: MIDI channel (0-15) whose messages are emitted.
- `OMNI`, 0: when 1, messages on all channels are emitted.

Ports:
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset. One clock; reset is synchronous and active-high.
- `midi_rx_in` input 1: asynchronous serial line. Idle is high.
- `midi_event` output 24: last emitted event {status, data1, data2}. Held until the next event.
- `event_valid` output 1: one-cycle strobe, high in the cycle `midi_event` updates.
- `framing_error` output 1: one-cycle strobe when a received byte has a low stop bit.

## Operation
- **Input sync:** `midi_rx_in` passes through a 2-FF synchronizer. Both FFs reset to 1.
- **UART receiver states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE → START on a synced low.
  - START: counts `BIT_CYC/2` cycles, then samples. If high (glitch) → IDLE. If low → DATA.
  - DATA: samples 8 bits, LSB first, every `BIT_CYC` cycles.
  - STOP: samples after `BIT_CYC`. If high, asserts the internal `byte_valid` for one cycle and → IDLE. If low, pulses `framing_error`, drops the byte and → WAIT_HIGH.
  - WAIT_HIGH → IDLE on the first synced high.
- **Parser states:** P_IDLE, P_D1, P_D2. A running-status register `rs` carries a valid flag.
- **Byte classes, in priority order:**
  - 0xF8-0xFF (real-time): ignored entirely. No change to state, `rs` or partial data.
  - 0xF0-0xF7 (system common/SysEx): clears `rs` valid and → P_IDLE. Data bytes are then discarded until the next status byte.
  - 0x80-0xEF (channel status): loads `rs`.
    - Types C/D (2-byte message) → P_D2 with `data2 = 0` pending.
    - Others → P_D1.
    - Any partial message is abandoned.
  - 0x00-0x7F (data):
    - In P_IDLE with `rs` valid: treated as data1. The byte count follows `rs`, so C/D messages complete immediately.
    - In P_IDLE without `rs`: discarded.
    - In P_D1: stored as data1, → P_D2.
    - In P_D2: completes the message and → P_IDLE. Types C/D arrive here via the first data byte.
- **Completion:** if `OMNI` or `rs[3:0] == CHANNEL`, the block loads `midi_event` and asserts `event_valid`. Otherwise the message is dropped silently. `rs` is retained in both cases.
- **Note-on, velocity 0:** emitted as {8'h80 | ch, note, 8'h00}.
- **2-byte messages (Cx, Dx):** emitted as {status, data1, 8'h00}.

## Timing
- **Reset values:**
  - `midi_event` = 24'h0, `event_valid` = 0, `framing_error` = 0.
  - UART → IDLE, parser → P_IDLE, `rs` invalid.
  - Reset mid-byte or mid-message discards everything in progress.
- **Sample points:** each sample is taken on the cycle the counter expires. Counter width is `$clog2(BIT_CYC)`.
- **Latency, line to byte:** `byte_valid` rises 1 cycle after the stop-bit sample.
- **Latency, byte to event:** `event_valid` and the new `midi_event` occur 1 cycle after the completing `byte_valid`, both registered.
- **Framing error:** `framing_error` is asserted in the cycle the stop bit is sampled.
- **Event rate:** at most one event per received byte. `event_valid` never occurs on consecutive cycles.
- **No backpressure:** the consumer must sample on `event_valid`, or use the held `midi_event`.
- **Reception during emission:** a new start bit is accepted in the cycle after STOP. Back-to-back bytes with no idle gap are received.

## Test plan
Bench uses `CLK_HZ = 3_125_000`, which gives 100 cycles/bit.
- **Basic events:**
  - 0x90, 0x4B, 0x64 serial → one `event_valid`, `midi_event` = 24'h904B64.
  - 0x80, 0x4B, 0x00 → 24'h804B00.
- **Running status and note-on velocity 0:**
  - 0x90 0x3C 0x40 0x3E 0x40 → two events, 24'h903C40 then 24'h903E40.
  - Then 0x3C 0x00 → 24'h803C00.
- **Real-time and SysEx:**
  - 0xB0 0xF8 0x46 0xFE 0x06 → single event 24'hB04606.
  - 0xF0 0x01 0x02 0xF7 0x30 0x40 → no event.
- **2-byte message and channel filter:**
  - 0xE0 0x00 0x40 → 24'hE00040.
  - 0xC0 0x05 → 24'hC00500.
  - 0x91 0x3C 0x40 with `CHANNEL = 0` → no event.
  - Same with `OMNI = 1` → 24'h913C40.
- **Errors and glitches:**
  - Byte with stop bit low → `framing_error` pulse, no event, `midi_event` unchanged.
  - 30-cycle low glitch on idle line → no byte, no error.
- **Reset mid-message:** 0x90 0x3C, then `rst_in` for 1 cycle, then 0x40 → no event and `midi_event` = 0.
